// File: rtl/whackamole_game_ctrl.sv
// Whack-a-mole round sequencer: spawns LFSR-placed moles, times their exposure and
// mediates evaluator hits. Define WHACK_SPEEDUP_EN to shorten the exposure as correct hits accumulate.
module whackamole_game_ctrl #(
    parameter int unsigned MOLE_TICKS   = 50000000,
    parameter int unsigned GAME_ROUNDS  = 30,
    parameter int unsigned MAX_MISSES   = 5,
    parameter int unsigned RESP_TIMEOUT = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [2:0] btn_code,
    input  logic       guess_correct,
    input  logic       guess_wrong,
    input  logic       guess_now,
    output logic       eval_rst,
    output logic       eval_now,
    output logic [2:0] user_guess,
    output logic [2:0] mole_pos,
    output logic       mole_change,
    output logic       game_active,
    output logic       game_over,
    output logic [7:0] round,
    output logic [3:0] misses,
    output logic       resp_err
);

    // Timer headroom covers a full exposure plus a response wait that overruns it.
    localparam int unsigned TMR_W  = $clog2(MOLE_TICKS + RESP_TIMEOUT + 2);
    localparam int unsigned RESP_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_ACTIVE    = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_PENALTY   = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TMR_W-1:0]   timer_q, timer_d, timer_inc, mole_last;
    logic [RESP_W-1:0]  resp_cnt_q, resp_cnt_d;
    logic [2:0]         cand, next_mole;
    logic [3:0]         misses_inc;

    logic               eval_rst_d, eval_now_d, mole_change_d;
    logic               game_active_d, game_over_d, resp_err_d;
    logic [2:0]         user_guess_d, mole_pos_d;
    logic [7:0]         round_d;
    logic [3:0]         misses_d;

`ifdef WHACK_SPEEDUP_EN
    localparam logic [TMR_W-1:0] SPD_FULL  = TMR_W'(MOLE_TICKS);
    localparam logic [TMR_W-1:0] SPD_STEP  = TMR_W'(MOLE_TICKS / 8);
    localparam logic [TMR_W-1:0] SPD_FLOOR = TMR_W'(MOLE_TICKS / 4);

    logic [TMR_W-1:0] tick_lim_q, tick_lim_d;
    logic [2:0]       hit_cnt_q, hit_cnt_d;

    assign mole_last = tick_lim_q - TMR_W'(1);
`else
    assign mole_last = TMR_W'(MOLE_TICKS - 1);
`endif

    // Fibonacci LFSR, taps 16/14/13/11, free-running in every state.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    assign cand       = lfsr_q[2:0];
    assign next_mole  = (cand == mole_pos) ? cand + 3'd1 : cand;
    assign timer_inc  = (&timer_q) ? timer_q : timer_q + TMR_W'(1);
    assign misses_inc = (&misses) ? misses : misses + 4'd1;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        resp_cnt_d    = resp_cnt_q;
        eval_rst_d    = 1'b0;
        eval_now_d    = 1'b0;
        mole_change_d = 1'b0;
        user_guess_d  = user_guess;
        mole_pos_d    = mole_pos;
        round_d       = round;
        misses_d      = misses;
        resp_err_d    = resp_err;
`ifdef WHACK_SPEEDUP_EN
        tick_lim_d    = tick_lim_q;
        hit_cnt_d     = hit_cnt_q;
`endif

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    eval_rst_d = 1'b1;
                    round_d    = '0;
                    misses_d   = '0;
                    resp_err_d = 1'b0;
                    state_d    = S_SPAWN;
`ifdef WHACK_SPEEDUP_EN
                    tick_lim_d = SPD_FULL;
                    hit_cnt_d  = '0;
`endif
                end
            end

            S_SPAWN: begin
                if (round >= 8'(GAME_ROUNDS) || misses >= 4'(MAX_MISSES)) begin
                    state_d = S_GAME_OVER;
                end else begin
                    mole_pos_d    = next_mole;
                    mole_change_d = 1'b1;
                    round_d       = round + 8'd1;
                    timer_d       = '0;
                    state_d       = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                timer_d = timer_inc;
                // Expiry wins over a coincident button press.
                if (timer_q >= mole_last) begin
                    misses_d = misses_inc;
                    state_d  = S_SPAWN;
                end else if (btn_valid && guess_now) begin
                    user_guess_d = btn_code;
                    eval_now_d   = 1'b1;
                    resp_cnt_d   = '0;
                    state_d      = S_WAIT_RESP;
                end
            end

            S_WAIT_RESP: begin
                timer_d = timer_inc;
                if (guess_wrong) begin
                    misses_d = misses_inc;
                    state_d  = S_PENALTY;
                end else if (guess_correct) begin
                    state_d = S_SPAWN;
`ifdef WHACK_SPEEDUP_EN
                    hit_cnt_d = hit_cnt_q + 3'd1;
                    if (hit_cnt_q == 3'd7) begin
                        tick_lim_d = (tick_lim_q >= SPD_FLOOR + SPD_STEP) ?
                                     tick_lim_q - SPD_STEP : SPD_FLOOR;
                    end
`endif
                end else if (resp_cnt_q == RESP_W'(RESP_TIMEOUT - 1)) begin
                    resp_err_d = 1'b1;
                    state_d    = S_ACTIVE;
                end else begin
                    resp_cnt_d = resp_cnt_q + RESP_W'(1);
                end
            end

            S_PENALTY: begin
                if (guess_now) begin
                    state_d = S_SPAWN;
                end
            end

            default: state_d = S_IDLE;
        endcase

        game_active_d = (state_d == S_SPAWN) || (state_d == S_ACTIVE) ||
                        (state_d == S_WAIT_RESP) || (state_d == S_PENALTY);
        game_over_d   = (state_d == S_GAME_OVER);
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            timer_q     <= '0;
            resp_cnt_q  <= '0;
            eval_rst    <= 1'b0;
            eval_now    <= 1'b0;
            user_guess  <= '0;
            mole_pos    <= '0;
            mole_change <= 1'b0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            round       <= '0;
            misses      <= '0;
            resp_err    <= 1'b0;
`ifdef WHACK_SPEEDUP_EN
            tick_lim_q  <= SPD_FULL;
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            timer_q     <= timer_d;
            resp_cnt_q  <= resp_cnt_d;
            eval_rst    <= eval_rst_d;
            eval_now    <= eval_now_d;
            user_guess  <= user_guess_d;
            mole_pos    <= mole_pos_d;
            mole_change <= mole_change_d;
            game_active <= game_active_d;
            game_over   <= game_over_d;
            round       <= round_d;
            misses      <= misses_d;
            resp_err    <= resp_err_d;
`ifdef WHACK_SPEEDUP_EN
            tick_lim_q  <= tick_lim_d;
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// Directed bench for whackamole_game_ctrl: short moles, three-round games, scripted evaluator.
module tb_whackamole_game_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, btn_valid, guess_correct, guess_wrong, guess_now;
    logic [2:0] btn_code;
    logic       eval_rst, eval_now, mole_change, game_active, game_over, resp_err;
    logic [2:0] user_guess, mole_pos;
    logic [7:0] round;
    logic [3:0] misses;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr, m_prev;
    logic [2:0]  exp_mole;

    whackamole_game_ctrl #(
        .MOLE_TICKS  (16),
        .GAME_ROUNDS (3),
        .MAX_MISSES  (5),
        .RESP_TIMEOUT(8),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .btn_valid    (btn_valid),
        .btn_code     (btn_code),
        .guess_correct(guess_correct),
        .guess_wrong  (guess_wrong),
        .guess_now    (guess_now),
        .eval_rst     (eval_rst),
        .eval_now     (eval_now),
        .user_guess   (user_guess),
        .mole_pos     (mole_pos),
        .mole_change  (mole_change),
        .game_active  (game_active),
        .game_over    (game_over),
        .round        (round),
        .misses       (misses),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value the DUT sampled at the latest edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mole(input string tag);
        logic [2:0] c, e;
        c = m_prev[2:0];
        e = (c == exp_mole) ? c + 3'd1 : c;
        check(tag, 16'(mole_pos), 16'(e));
        exp_mole = e;
    endtask

    task automatic check_all_zero(input string tag);
        logic [15:0] v;
        v = {1'b0, eval_rst, eval_now, user_guess, mole_pos, mole_change,
             game_active, game_over, resp_err, 3'b000};
        check({tag, "_ctl"}, v, 16'd0);
        check({tag, "_cnt"}, {4'd0, round, misses}, 16'd0);
    endtask

    task automatic wait_mole(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mole_change && n < 64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         pen_evals, pen_moves;
        logic [2:0] old;

        rst_n = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_code = 3'd0;
        guess_correct = 1'b0; guess_wrong = 1'b0; guess_now = 1'b1;
        exp_mole = 3'd0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Game 1: start, then let every mole time out.
        start = 1'b1;
        tick();
        check("start_eval_rst", 16'(eval_rst), 16'd1);
        check("start_active", 16'(game_active), 16'd1);
        check("start_no_mole_yet", 16'(mole_change), 16'd0);
        start = 1'b0;
        tick();
        check("eval_rst_one_cycle", 16'(eval_rst), 16'd0);
        check("first_mole_change", 16'(mole_change), 16'd1);
        check("first_round", 16'(round), 16'd1);
        check("first_misses", 16'(misses), 16'd0);
        check_mole("first_mole_pos");

        wait_mole(n);
        check("period_r2", 16'(n), 16'd17);
        check("round_r2", 16'(round), 16'd2);
        check("misses_r2", 16'(misses), 16'd1);
        check_mole("mole_pos_r2");
        wait_mole(n);
        check("period_r3", 16'(n), 16'd17);
        check("round_r3", 16'(round), 16'd3);
        check("misses_r3", 16'(misses), 16'd2);
        check_mole("mole_pos_r3");

        repeat (16) tick();
        check("timeout3_misses", 16'(misses), 16'd3);
        check("timeout3_still_active", 16'(game_active), 16'd1);
        tick();
        check("go_game_over", 16'(game_over), 16'd1);
        check("go_inactive", 16'(game_active), 16'd0);
        check("go_round", 16'(round), 16'd3);
        check("go_misses", 16'(misses), 16'd3);
        repeat (3) tick();
        check("go_hold", 16'(game_over), 16'd1);
        check("go_mole_hold", 16'(mole_pos), 16'(exp_mole));

        // Game 2: restart from GAME_OVER, then a correct hit.
        start = 1'b1;
        tick();
        check("restart_eval_rst", 16'(eval_rst), 16'd1);
        check("restart_round_clr", 16'(round), 16'd0);
        check("restart_misses_clr", 16'(misses), 16'd0);
        check("restart_go_clr", 16'(game_over), 16'd0);
        start = 1'b0;
        tick();
        check("g2_mole_change", 16'(mole_change), 16'd1);
        check_mole("g2_mole_pos");
        tick(); tick();
        old = mole_pos;
        btn_valid = 1'b1; btn_code = old;
        tick();
        check("hit_eval_now", 16'(eval_now), 16'd1);
        check("hit_user_guess", 16'(user_guess), 16'(old));
        btn_valid = 1'b0; btn_code = ~old; guess_correct = 1'b1;
        tick();
        check("hit_eval_now_pulse", 16'(eval_now), 16'd0);
        check("hit_user_guess_stable", 16'(user_guess), 16'(old));
        guess_correct = 1'b0;
        tick();
        check("hit_mole_change", 16'(mole_change), 16'd1);
        check("hit_new_pos", 16'(mole_pos != old), 16'd1);
        check("hit_round", 16'(round), 16'd2);
        check("hit_misses", 16'(misses), 16'd0);
        check_mole("hit_mole_pos");

        // Wrong hit followed by a long penalty with button chatter.
        old = mole_pos;
        btn_valid = 1'b1; btn_code = old + 3'd1;
        tick();
        check("wrong_eval_now", 16'(eval_now), 16'd1);
        btn_valid = 1'b0; guess_wrong = 1'b1; guess_now = 1'b0;
        tick();
        check("wrong_misses", 16'(misses), 16'd1);
        check("wrong_active", 16'(game_active), 16'd1);
        guess_wrong = 1'b0;
        pen_evals = 0; pen_moves = 0;
        for (int i = 0; i < 20; i++) begin
            btn_valid = (i % 3 == 0);
            btn_code  = 3'(i);
            tick();
            if (eval_now) pen_evals++;
            if (mole_change) pen_moves++;
        end
        check("penalty_eval_now", 16'(pen_evals), 16'd0);
        check("penalty_mole_change", 16'(pen_moves), 16'd0);
        btn_valid = 1'b0; guess_now = 1'b1;
        tick();
        check("penalty_exit_spawn", 16'(mole_change), 16'd0);
        tick();
        check("penalty_mole_change_after", 16'(mole_change), 16'd1);
        check("penalty_round", 16'(round), 16'd3);
        check("penalty_misses", 16'(misses), 16'd1);
        check_mole("penalty_mole_pos");

        // Evaluator silence: response timeout, then a later hit ends the game.
        btn_valid = 1'b1; btn_code = 3'd3;
        tick();
        check("silent_eval_now", 16'(eval_now), 16'd1);
        btn_valid = 1'b0;
        repeat (7) tick();
        check("silent_no_err_yet", 16'(resp_err), 16'd0);
        tick();
        check("silent_resp_err", 16'(resp_err), 16'd1);
        check("silent_active", 16'(game_active), 16'd1);
        btn_valid = 1'b1; btn_code = 3'd5;
        tick();
        check("silent_back_active", 16'(eval_now), 16'd1);
        check("silent_user_guess", 16'(user_guess), 16'd5);
        btn_valid = 1'b0; guess_correct = 1'b1;
        tick();
        guess_correct = 1'b0;
        tick();
        check("g2_game_over", 16'(game_over), 16'd1);
        check("g2_round", 16'(round), 16'd3);
        check("g2_misses", 16'(misses), 16'd1);
        check("g2_err_sticky", 16'(resp_err), 16'd1);
        start = 1'b1;
        tick();
        check("start_clears_err", 16'(resp_err), 16'd0);
        start = 1'b0;
        tick();
        check("g3_mole_change", 16'(mole_change), 16'd1);
        check_mole("g3_mole_pos");

        // start and penalised buttons ignored in-game, then async reset in WAIT_RESP.
        start = 1'b1;
        tick();
        check("start_ignored", 16'(eval_rst), 16'd0);
        check("start_ignored_round", 16'(round), 16'd1);
        start = 1'b0; guess_now = 1'b0; btn_valid = 1'b1;
        tick();
        check("btn_not_ready", 16'(eval_now), 16'd0);
        guess_now = 1'b1;
        tick();
        check("g3_eval_now", 16'(eval_now), 16'd1);
        btn_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_mole = 3'd0;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        check("post_reset_eval_rst", 16'(eval_rst), 16'd1);
        start = 1'b0;
        tick();
        check("post_reset_mole_change", 16'(mole_change), 16'd1);
        check("post_reset_round", 16'(round), 16'd1);
        check("post_reset_misses", 16'(misses), 16'd0);
        check_mole("post_reset_mole_pos");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
